// File: rtl/axis_frame_gen_pkg.sv
// Shared encodings for the synthetic AXI4-Stream frame source.
package axis_frame_gen_pkg;

    // Pixel pattern selection, sampled at frame start
    localparam logic [1:0] MODE_SOLID  = 2'd0;
    localparam logic [1:0] MODE_HRAMP  = 2'd1;
    localparam logic [1:0] MODE_VRAMP  = 2'd2;
    localparam logic [1:0] MODE_WINDOW = 2'd3;

    // Generator control state
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/axis_frame_gen_raster_counter.sv
// Raster row/col tracker for a one-pixel-per-beat stream. The registered
// position is the beat currently held downstream; row/col/sof/eol describe
// the beat that will be loaded next, eof flags the held beat as frame-final.
module raster_counter
    import axis_frame_gen_pkg::*;
#(
    parameter int HW = 12,
    parameter int WW = 12
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          load,
    input  logic          advance,
    input  logic [HW-1:0] load_h,
    input  logic [WW-1:0] load_w,
    output logic [HW-1:0] row,
    output logic [WW-1:0] col,
    output logic          sof,
    output logic          eol,
    output logic          eof
);

    logic [HW-1:0] row_q, h_q;
    logic [WW-1:0] col_q, w_q;
    logic [WW-1:0] w_n;
    logic          cur_eol;

    assign cur_eol = (col_q == w_q - WW'(1));
    assign eof     = cur_eol && (row_q == h_q - HW'(1));

    // Next position: restart at origin on load, otherwise step in raster order
    always_comb begin
        w_n = load ? load_w : w_q;
        row = row_q;
        col = col_q;
        if (load) begin
            row = '0;
            col = '0;
        end else if (advance) begin
            if (cur_eol) begin
                col = '0;
                row = eof ? '0 : row_q + HW'(1);
            end else begin
                col = col_q + WW'(1);
            end
        end
        sof = (row == '0) && (col == '0);
        eol = (col == w_n - WW'(1));
    end

    // Position and geometry registers; geometry only changes on load
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            row_q <= '0;
            col_q <= '0;
            h_q   <= '0;
            w_q   <= '0;
        end else begin
            row_q <= row;
            col_q <= col;
            if (load) begin
                h_q <= load_h;
                w_q <= load_w;
            end
        end
    end

endmodule

// File: rtl/axis_frame_gen.sv
// Synthetic AXI4-Stream video frame source: one frame per fsync, raster order,
// tuser on the first pixel, tlast on each line end, optional one-deep re-trigger.
module axis_frame_gen
    import axis_frame_gen_pkg::*;
#(
    parameter int C_PIXEL_WIDTH = 8,
    parameter int C_IMG_HW      = 12,
    parameter int C_IMG_WW      = 12
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic [C_IMG_HW-1:0]      height,
    input  logic [C_IMG_WW-1:0]      width,
    input  logic [1:0]               mode,
    input  logic [C_PIXEL_WIDTH-1:0] base,
    input  logic [C_PIXEL_WIDTH-1:0] fg,
    input  logic [C_IMG_WW-1:0]      win_left,
    input  logic [C_IMG_WW-1:0]      win_width,
    input  logic [C_IMG_HW-1:0]      win_top,
    input  logic [C_IMG_HW-1:0]      win_height,
    input  logic                     fsync,
    output logic                     busy,
    output logic                     frame_done,
    output logic                     m_axis_tvalid,
    output logic [C_PIXEL_WIDTH-1:0] m_axis_tdata,
    output logic                     m_axis_tuser,
    output logic                     m_axis_tlast,
    input  logic                     m_axis_tready
);

    localparam int PW = C_PIXEL_WIDTH;
    localparam int HW = C_IMG_HW;
    localparam int WW = C_IMG_WW;

    state_t        state;
    logic          pending;

    logic [1:0]    mode_q, mode_n;
    logic [PW-1:0] base_q, base_n, fg_q, fg_n;
    logic [WW-1:0] wl_q, wl_n, ww_q, ww_n;
    logic [HW-1:0] wt_q, wt_n, wh_q, wh_n;

    logic [HW-1:0] nxt_row;
    logic [WW-1:0] nxt_col;
    logic          nxt_sof, nxt_eol, cur_eof;
    logic          accept, last, cfg_ok, start, restart, load;
    logic [PW-1:0] pix_nxt;

    // Window compare uses one extra bit so left+width past the frame edge clips
    function automatic logic [PW-1:0] pixel_at(
        input logic [1:0]    m,
        input logic [PW-1:0] b,
        input logic [PW-1:0] f,
        input logic [HW-1:0] r,
        input logic [WW-1:0] c,
        input logic [WW-1:0] wl,
        input logic [WW-1:0] ww,
        input logic [HW-1:0] wt,
        input logic [HW-1:0] wh
    );
        logic [WW:0]   c_end;
        logic [HW:0]   r_end;
        logic          in_win;
        logic [PW-1:0] p;
        c_end  = {1'b0, wl} + {1'b0, ww};
        r_end  = {1'b0, wt} + {1'b0, wh};
        in_win = (c >= wl) && ({1'b0, c} < c_end) &&
                 (r >= wt) && ({1'b0, r} < r_end);
        case (m)
            MODE_SOLID: p = b;
            MODE_HRAMP: p = b + PW'(c);
            MODE_VRAMP: p = b + PW'(r);
            default:    p = in_win ? f : b + PW'(c);
        endcase
        return p;
    endfunction

    assign accept  = m_axis_tvalid && m_axis_tready;
    assign last    = accept && cur_eof;
    assign cfg_ok  = (height != '0) && (width != '0);
    assign start   = (state == ST_IDLE) && fsync && cfg_ok;
    // A re-trigger arriving on the very last accept is treated like a pending one
    assign restart = last && (pending || fsync) && cfg_ok;
    assign load    = start || restart;

    raster_counter #(
        .HW (HW),
        .WW (WW)
    ) u_raster (
        .clk     (clk),
        .resetn  (resetn),
        .load    (load),
        .advance (accept),
        .load_h  (height),
        .load_w  (width),
        .row     (nxt_row),
        .col     (nxt_col),
        .sof     (nxt_sof),
        .eol     (nxt_eol),
        .eof     (cur_eof)
    );

    // Config seen by the next beat: live inputs at frame start, latched copy otherwise
    always_comb begin
        mode_n = mode_q;
        base_n = base_q;
        fg_n   = fg_q;
        wl_n   = wl_q;
        ww_n   = ww_q;
        wt_n   = wt_q;
        wh_n   = wh_q;
        if (load) begin
            mode_n = mode;
            base_n = base;
            fg_n   = fg;
            wl_n   = win_left;
            ww_n   = win_width;
            wt_n   = win_top;
            wh_n   = win_height;
        end
    end

    assign pix_nxt = pixel_at(mode_n, base_n, fg_n, nxt_row, nxt_col,
                              wl_n, ww_n, wt_n, wh_n);

    // Latch pattern configuration at each frame start
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mode_q <= '0;
            base_q <= '0;
            fg_q   <= '0;
            wl_q   <= '0;
            ww_q   <= '0;
            wt_q   <= '0;
            wh_q   <= '0;
        end else if (load) begin
            mode_q <= mode_n;
            base_q <= base_n;
            fg_q   <= fg_n;
            wl_q   <= wl_n;
            ww_q   <= ww_n;
            wt_q   <= wt_n;
            wh_q   <= wh_n;
        end
    end

    // Control FSM with the registered stream outputs
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state         <= ST_IDLE;
            pending       <= 1'b0;
            busy          <= 1'b0;
            frame_done    <= 1'b0;
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tuser  <= 1'b0;
            m_axis_tlast  <= 1'b0;
        end else begin
            frame_done <= last;
            if (load) begin
                state         <= ST_RUN;
                busy          <= 1'b1;
                pending       <= 1'b0;
                m_axis_tvalid <= 1'b1;
                m_axis_tdata  <= pix_nxt;
                m_axis_tuser  <= nxt_sof;
                m_axis_tlast  <= nxt_eol;
            end else if (last) begin
                state         <= ST_IDLE;
                busy          <= 1'b0;
                pending       <= 1'b0;
                m_axis_tvalid <= 1'b0;
                m_axis_tdata  <= '0;
                m_axis_tuser  <= 1'b0;
                m_axis_tlast  <= 1'b0;
            end else begin
                if (state == ST_RUN && fsync)
                    pending <= 1'b1;
                if (accept) begin
                    m_axis_tdata <= pix_nxt;
                    m_axis_tuser <= nxt_sof;
                    m_axis_tlast <= nxt_eol;
                end
            end
        end
    end

endmodule

// File: tb/tb_axis_frame_gen.sv
// Scoreboard bench for axis_frame_gen: frames are expanded into expected beats
// from the pattern rules when fsync is issued; a monitor pops on every accept.
module tb_axis_frame_gen;

    localparam int PW = 8;
    localparam int HW = 12;
    localparam int WW = 12;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic [HW-1:0] height = '0;
    logic [WW-1:0] width = '0;
    logic [1:0]    mode = '0;
    logic [PW-1:0] base = '0;
    logic [PW-1:0] fg = '0;
    logic [WW-1:0] win_left = '0;
    logic [WW-1:0] win_width = '0;
    logic [HW-1:0] win_top = '0;
    logic [HW-1:0] win_height = '0;
    logic          fsync = 1'b0;
    logic          busy, frame_done;
    logic          m_axis_tvalid, m_axis_tuser, m_axis_tlast;
    logic [PW-1:0] m_axis_tdata;
    logic          m_axis_tready = 1'b1;

    always #5 clk = ~clk;

    axis_frame_gen #(
        .C_PIXEL_WIDTH (PW),
        .C_IMG_HW      (HW),
        .C_IMG_WW      (WW)
    ) dut (
        .clk           (clk),
        .resetn        (resetn),
        .height        (height),
        .width         (width),
        .mode          (mode),
        .base          (base),
        .fg            (fg),
        .win_left      (win_left),
        .win_width     (win_width),
        .win_top       (win_top),
        .win_height    (win_height),
        .fsync         (fsync),
        .busy          (busy),
        .frame_done    (frame_done),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tuser  (m_axis_tuser),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tready (m_axis_tready)
    );

    typedef struct {
        logic [PW-1:0] d;
        logic          u;
        logic          l;
        logic          e;
    } beat_t;

    beat_t         q[$];
    int            frames_in_q = 0;
    int            total = 0;
    int            bad = 0;
    bit            rnd_rdy = 1'b0;
    int            beat_cnt = 0;
    int            tlast_cnt = 0;
    int            tuser_cnt = 0;
    logic [PW-1:0] cap [1024];

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Reference frame: pixel rules evaluated with plain integer arithmetic
    task automatic push_frame(input int h, input int w, input int m, input int b,
                              input int f, input int wl, input int ww,
                              input int wt, input int wh);
        for (int r = 0; r < h; r++) begin
            for (int c = 0; c < w; c++) begin
                int    v;
                beat_t bt;
                case (m)
                    0:       v = b;
                    1:       v = b + c;
                    2:       v = b + r;
                    default: v = (c >= wl && c < wl + ww && r >= wt && r < wt + wh) ? f : b + c;
                endcase
                bt.d = 8'(v % 256);
                bt.u = (r == 0 && c == 0);
                bt.l = (c == w - 1);
                bt.e = (r == h - 1 && c == w - 1);
                q.push_back(bt);
            end
        end
    endtask

    // Pulse fsync for one cycle; the model decides start / pending / drop
    task automatic do_fsync();
        bit take;
        int h, w, m, b, f, wl, ww, wt, wh;
        fsync = 1'b1;
        take = (frames_in_q < 2);
        h = height; w = width; m = mode; b = base; f = fg;
        wl = win_left; ww = win_width; wt = win_top; wh = win_height;
        @(posedge clk); #1;
        fsync = 1'b0;
        if (take && h != 0 && w != 0) begin
            push_frame(h, w, m, b, f, wl, ww, wt, wh);
            frames_in_q++;
        end
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 5000) begin
            @(posedge clk);
            n++;
        end
        if (q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: got %0d beats left want 0", q.size());
            q.delete();
            frames_in_q = 0;
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic set_cfg(input int h, input int w, input int m, input int b,
                           input int f, input int wl, input int wt,
                           input int ww, input int wh);
        height = HW'(h); width = WW'(w); mode = 2'(m); base = PW'(b); fg = PW'(f);
        win_left = WW'(wl); win_top = HW'(wt); win_width = WW'(ww); win_height = HW'(wh);
    endtask

    task automatic clr_cnt();
        beat_cnt = 0; tlast_cnt = 0; tuser_cnt = 0;
    endtask

    // Ready driver
    initial begin
        forever begin
            @(posedge clk); #1;
            m_axis_tready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor / scoreboard
    initial begin
        logic          pv_stall, exp_fd, nfd;
        logic [PW-1:0] pd;
        logic          pu, pl;
        beat_t         bt;
        pv_stall = 1'b0; exp_fd = 1'b0; pd = '0; pu = 1'b0; pl = 1'b0;
        forever begin
            @(negedge clk);
            if (!resetn) begin
                pv_stall = 1'b0;
                exp_fd   = 1'b0;
            end else begin
                nfd = 1'b0;
                if (exp_fd || frame_done) check("frame_done", frame_done, exp_fd);
                check("tvalid", m_axis_tvalid, q.size() != 0);
                check("busy", busy, q.size() != 0);
                if (pv_stall) begin
                    check("stall_tvalid", m_axis_tvalid, 1);
                    check("stall_tdata", m_axis_tdata, pd);
                    check("stall_tuser", m_axis_tuser, pu);
                    check("stall_tlast", m_axis_tlast, pl);
                end
                if (m_axis_tvalid && m_axis_tready && q.size() != 0) begin
                    bt = q.pop_front();
                    check("tdata", m_axis_tdata, bt.d);
                    check("tuser", m_axis_tuser, bt.u);
                    check("tlast", m_axis_tlast, bt.l);
                    if (beat_cnt < 1024) cap[beat_cnt] = m_axis_tdata;
                    beat_cnt++;
                    tlast_cnt += int'(m_axis_tlast);
                    tuser_cnt += int'(m_axis_tuser);
                    if (bt.e) begin
                        frames_in_q--;
                        nfd = 1'b1;
                    end
                end
                pv_stall = m_axis_tvalid && !m_axis_tready;
                pd = m_axis_tdata; pu = m_axis_tuser; pl = m_axis_tlast;
                exp_fd = nfd;
            end
        end
    end

    initial begin
        // Reset state
        resetn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_tvalid", m_axis_tvalid, 0);
        check("rst_tdata", m_axis_tdata, 0);
        check("rst_tuser", m_axis_tuser, 0);
        check("rst_tlast", m_axis_tlast, 0);
        check("rst_busy", busy, 0);
        check("rst_frame_done", frame_done, 0);
        resetn = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Basic raster
        set_cfg(4, 5, 0, 8'h80, 0, 0, 0, 0, 0);
        clr_cnt();
        do_fsync();
        drain();
        check("basic_beats", beat_cnt, 20);
        check("basic_tlasts", tlast_cnt, 4);
        check("basic_tusers", tuser_cnt, 1);

        // Window pattern
        set_cfg(20, 40, 3, 128, 10, 15, 5, 12, 3);
        clr_cnt();
        do_fsync();
        drain();
        check("win_beats", beat_cnt, 800);
        check("win_tlasts", tlast_cnt, 20);
        check("win_r6c20", cap[6*40+20], 10);
        check("win_r6c14", cap[6*40+14], 142);
        check("win_r8c20", cap[8*40+20], 148);

        // Backpressure on a column ramp
        rnd_rdy = 1'b1;
        set_cfg(3, 8, 1, 0, 0, 0, 0, 0, 0);
        clr_cnt();
        do_fsync();
        drain();
        check("bp_beats", beat_cnt, 24);
        rnd_rdy = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Back-to-back frames with a dropped extra sync
        set_cfg(2, 4, 1, 8'h20, 0, 0, 0, 0, 0);
        clr_cnt();
        do_fsync();
        repeat (3) @(posedge clk);
        #1;
        do_fsync();
        repeat (3) @(posedge clk);
        #1;
        do_fsync();
        drain();
        check("b2b_frames", tuser_cnt, 2);
        check("b2b_beats", beat_cnt, 16);

        // Boundary geometry
        set_cfg(3, 1, 2, 5, 0, 0, 0, 0, 0);
        clr_cnt();
        do_fsync();
        drain();
        check("w1_tlasts", tlast_cnt, 3);

        set_cfg(0, 5, 0, 1, 0, 0, 0, 0, 0);
        clr_cnt();
        do_fsync();
        repeat (4) @(posedge clk);
        #1;
        check("h0_busy", busy, 0);
        check("h0_beats", beat_cnt, 0);
        set_cfg(3, 0, 0, 1, 0, 0, 0, 0, 0);
        do_fsync();
        repeat (4) @(posedge clk);
        #1;
        check("w0_busy", busy, 0);
        check("w0_beats", beat_cnt, 0);

        set_cfg(1, 3, 1, 8'hFF, 0, 0, 0, 0, 0);
        clr_cnt();
        do_fsync();
        drain();
        check("wrap_px0", cap[0], 8'hFF);
        check("wrap_px1", cap[1], 8'h00);
        check("wrap_px2", cap[2], 8'h01);
        check("h1_tusers", tuser_cnt, 1);

        // Config change mid-frame has no effect on the running frame
        set_cfg(3, 6, 2, 8'h10, 0, 0, 0, 0, 0);
        do_fsync();
        repeat (4) @(posedge clk);
        #1;
        set_cfg(5, 2, 0, 8'hAA, 0, 0, 0, 0, 0);
        drain();

        // Randomized frames, with occasional re-trigger under backpressure
        rnd_rdy = 1'b1;
        for (int k = 0; k < 8; k++) begin
            set_cfg($urandom_range(1, 6), $urandom_range(1, 10), $urandom_range(0, 3),
                    $urandom_range(0, 255), $urandom_range(0, 255),
                    $urandom_range(0, 12), $urandom_range(0, 8),
                    $urandom_range(0, 12), $urandom_range(0, 8));
            do_fsync();
            if ($urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(1, 4)) @(posedge clk);
                #1;
                do_fsync();
            end
            drain();
        end
        rnd_rdy = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Reset mid-frame
        set_cfg(4, 5, 0, 8'h33, 0, 0, 0, 0, 0);
        do_fsync();
        repeat (10) @(posedge clk);
        #1;
        resetn = 1'b0;
        #1;
        check("mrst_tvalid", m_axis_tvalid, 0);
        check("mrst_tdata", m_axis_tdata, 0);
        check("mrst_tuser", m_axis_tuser, 0);
        check("mrst_tlast", m_axis_tlast, 0);
        check("mrst_busy", busy, 0);
        check("mrst_frame_done", frame_done, 0);
        q.delete();
        frames_in_q = 0;
        @(posedge clk);
        #1;
        resetn = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        set_cfg(2, 3, 1, 8'h40, 0, 0, 0, 0, 0);
        clr_cnt();
        do_fsync();
        drain();
        check("post_rst_tusers", tuser_cnt, 1);
        check("post_rst_beats", beat_cnt, 6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/axis_frame_gen.md
# axis_frame_gen

AXI4-Stream video frame source for the fusion-splice analysis path. On an `fsync` pulse it emits one frame of `height` × `width` pixels in raster order with one pixel per beat. `tuser` marks start of frame and `tlast` marks end of line. The pixel content is a selectable synthetic pattern that produces exactly the fibre-gap/dark-band images `fsa` expects on `s_axis`. It replaces behavioural stimulus with synthesizable bring-up and self-test hardware ahead of the `fsa` input.

## Interface
- `C_PIXEL_WIDTH`, 8, pixel/tdata width
- `C_IMG_HW`, 12, height and row-counter width
- `C_IMG_WW`, 12, width and column-counter width
- `clk`  in  1  sole clock
- `resetn`  in  1  reset, asynchronous, active-low
- `height`  in  C_IMG_HW  frame rows, sampled at frame start
- `width`  in  C_IMG_WW  frame columns, sampled at frame start
- `mode`  in  2  pattern, sampled at frame start: 0 solid, 1 column ramp, 2 row ramp, 3 window
- `base`  in  C_PIXEL_WIDTH  background level
- `fg`  in  C_PIXEL_WIDTH  window foreground level
- `win_left`, `win_width`  in  C_IMG_WW  window columns, sampled at frame start
- `win_top`, `win_height`  in  C_IMG_HW  window rows, sampled at frame start
- `fsync`  in  1  one-cycle frame request
- `busy`  out  1  frame in progress
- `frame_done`  out  1  one-cycle pulse after the last beat is accepted
- `m_axis_tvalid`  out  1
- `m_axis_tdata`  out  C_PIXEL_WIDTH
- `m_axis_tuser`  out  1  first pixel of frame
- `m_axis_tlast`  out  1  last pixel of line
- `m_axis_tready`  in  1

## Operation
- States: IDLE, RUN.
- IDLE, `fsync`=1, `height`≠0 and `width`≠0:
  - latch all configuration inputs
  - clear row/col to 0
  - enter RUN
- `fsync` with zero `height` or `width` is ignored; the block stays IDLE.
- RUN: the output register holds beat (row, col). On accept (`tvalid && tready`):
  - col==w−1 → col=0; otherwise col+1
  - col==w−1 and row==h−1 → last beat; otherwise row advances on line wrap
- Beat fields:
  - `tuser` = (row==0 && col==0)
  - `tlast` = (col==w−1)
- Pixel value:
  - mode 0: `base`
  - mode 1: `base`+col, truncated to C_PIXEL_WIDTH (wraps modulo 2^C_PIXEL_WIDTH)
  - mode 2: `base`+row, truncated to C_PIXEL_WIDTH (wraps modulo 2^C_PIXEL_WIDTH)
  - mode 3: `fg` if win_left ≤ col < win_left+win_width and win_top ≤ row < win_top+win_height; otherwise `base`+col
- Window bound sums use one extra bit, so windows reaching past the frame clip cleanly with no wrap.
- `fsync` during RUN sets a one-deep pending flag; further `fsync` pulses while the flag is set are dropped.
- On last-beat accept:
  - pending set → re-latch configuration, start the next frame back-to-back (no idle cycle), clear pending
  - otherwise → IDLE
- Configuration changes mid-frame have no effect until the next frame start.

## Timing
- Reset values (async assert, sync release): `tvalid`, `tdata`, `tuser`, `tlast`, `busy`, `frame_done`, pending = 0; state IDLE; counters 0.
- Latency:
  - `fsync` high in cycle N → `tvalid`=1 with the first beat in N+1
  - `busy`=1 from N+1 through the last-beat accept cycle
- Throughput: one beat per cycle while `tready`=1, including line and frame boundaries.
- Handshake:
  - `tvalid`, once high, stays high until accepted
  - `tdata`, `tuser`, `tlast` are stable while `tvalid && !tready`
  - `tvalid` never depends combinationally on `tready`
- `frame_done` is high in the cycle after the last beat is accepted.
- When a back-to-back frame starts, the new first beat is valid in that same cycle.
- `resetn` asserted mid-frame aborts immediately: no `tlast` or `frame_done`, and pending is cleared.
- `width`=1: every beat has `tlast`=1.
- `height`=1: the frame is one line; `tuser` is on the first beat only.
- All registered outputs come from flops; there are no combinational paths from inputs to outputs.

## Structure
- Shared package: mode encodings `MODE_SOLID`=0, `MODE_HRAMP`=1, `MODE_VRAMP`=2, `MODE_WINDOW`=3 and the state encoding.
- One natural sub-module, `raster_counter`:
  - row/col counters with `advance`, `load`, latched w/h
  - outputs `sof`, `eol`, `eof`
  - reusable by later readers of the same stream
- Pixel generation is a combinational function of the next (row, col) feeding the output register.

## Test plan
- **Basic raster:** h=4, w=5, mode 0, base=0x80, `tready`=1, `fsync` pulse → 20 beats of 0x80 on consecutive cycles; `tuser` on beat 0 only; `tlast` on beats 4, 9, 14, 19; `frame_done` one cycle after beat 19; `busy` falls.
- **Window:** h=20, w=40, mode 3, base=128, fg=10, win=(15,5,12,3) →
  - row 6, col 20 = 10
  - row 6, col 14 = 142
  - row 8, col 20 = 148
  - total beats 800, 20 `tlast`s
- **Backpressure:** mode 1, base=0, w=8, random `tready` (50%) → beat sequence identical to the `tready`=1 run; `tdata`/`tuser`/`tlast` never change while stalled.
- **Back-to-back and dropped syncs:** `fsync` at beats 3 and 7 of an h=2, w=4 frame → exactly two frames; the second `tuser` beat directly follows the first frame's last beat with zero gap.
- **Boundary geometry:**
  - w=1, h=3 → three beats, all `tlast`
  - h=0 or w=0 with `fsync` → no `tvalid`, `busy` stays 0
  - mode 1, base=0xFF, w=3 → data FF, 00, 01
- **Reset mid-frame:** assert `resetn`=0 at beat 10 → outputs 0 within the same cycle (async); after release, no output until the next `fsync`, and that frame starts with `tuser`=1.
